// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op encoding and the
// mul/div FSM state type.
package ex_pkg;

    localparam logic [4:0] OpAdd    = 5'd0;
    localparam logic [4:0] OpSub    = 5'd1;
    localparam logic [4:0] OpSll    = 5'd2;
    localparam logic [4:0] OpSlt    = 5'd3;
    localparam logic [4:0] OpSltu   = 5'd4;
    localparam logic [4:0] OpXor    = 5'd5;
    localparam logic [4:0] OpSrl    = 5'd6;
    localparam logic [4:0] OpSra    = 5'd7;
    localparam logic [4:0] OpOr     = 5'd8;
    localparam logic [4:0] OpAnd    = 5'd9;
    localparam logic [4:0] OpPassB  = 5'd10;
    localparam logic [4:0] OpMul    = 5'd16;
    localparam logic [4:0] OpMulh   = 5'd17;
    localparam logic [4:0] OpMulhsu = 5'd18;
    localparam logic [4:0] OpMulhu  = 5'd19;
    localparam logic [4:0] OpDiv    = 5'd20;
    localparam logic [4:0] OpDivu   = 5'd21;
    localparam logic [4:0] OpRem    = 5'd22;
    localparam logic [4:0] OpRemu   = 5'd23;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_t;

    // Every op code with bit 4 set is routed to the iterative unit.
    function automatic logic is_muldiv(logic [4:0] op);
        return op[4];
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, WB forwarding inputs and EX/MEM outputs of the execute stage.
interface ex_stage_if;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_alu_op;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        ex_reg_write;
    logic        ex_alu_use_rs2;
    logic [31:0] ex_immediate;
    logic        ex_mem_write;
    logic        ex_mem_read;
    logic [2:0]  ex_mem_op_length;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_rs2_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_write;
    logic        mem_mem_read;
    logic [2:0]  mem_mem_op_length;
    logic        ex_stall;

    modport master (
        output ex_rs1_data, ex_rs2_data, ex_alu_op, ex_rd, ex_rs1, ex_rs2, ex_reg_write,
               ex_alu_use_rs2, ex_immediate, ex_mem_write, ex_mem_read, ex_mem_op_length,
               wb_rd, wb_reg_write, wb_data,
        input  mem_alu_result, mem_rs2_data, mem_rd, mem_reg_write, mem_mem_write,
               mem_mem_read, mem_mem_op_length, ex_stall
    );

    modport slave (
        input  ex_rs1_data, ex_rs2_data, ex_alu_op, ex_rd, ex_rs1, ex_rs2, ex_reg_write,
               ex_alu_use_rs2, ex_immediate, ex_mem_write, ex_mem_read, ex_mem_op_length,
               wb_rd, wb_reg_write, wb_data,
        output mem_alu_result, mem_rs2_data, mem_rd, mem_reg_write, mem_mem_write,
               mem_mem_read, mem_mem_op_length, ex_stall
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on operand
// magnitudes, sign fixed up from the latched operand signs in DONE.
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter int unsigned MULDIV_ITERS = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam int unsigned CntW = $clog2(MULDIV_ITERS + 1);

    md_state_t       state_q;
    logic [CntW-1:0] count_q;
    logic [4:0]      op_q;
    logic            neg_res_q, neg_rem_q, div_zero_q;
    logic [31:0]     dividend_q, divisor_q, rem_q;
    logic [31:0]     shreg_q;  // multiplier for mul, dividend/quotient for div
    logic [63:0]     prod_q, mcand_q;

    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_shift, diff;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    // Operand signedness from op bits: mul ops sign-extend by op[1:0], div ops by op[0].
    always_comb begin
        a_signed  = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_signed  = op[2] ? ~op[0] : ~op[1];
        a_neg     = a_signed & a[31];
        b_neg     = b_signed & b[31];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        rem_shift = {rem_q, shreg_q[31]};
        diff      = rem_shift - {1'b0, divisor_q};
    end

    // Result selection with sign fix-up; undefined M codes yield zero.
    always_comb begin
        prod_fix = neg_res_q ? -prod_q : prod_q;
        quot_fix = neg_res_q ? -shreg_q : shreg_q;
        rem_fix  = neg_rem_q ? -rem_q : rem_q;
        result   = '0;
        if (op_q[4:3] == 2'b10) begin
            if (!op_q[2]) begin
                result = (op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
            end else if (div_zero_q) begin
                result = op_q[1] ? dividend_q : '1;
            end else begin
                result = op_q[1] ? rem_fix : quot_fix;
            end
        end
    end

    assign busy = (state_q == StIdle && start) || state_q == StBusy;
    assign done = state_q == StDone;

    // FSM plus operand latches and one mul/div step per BUSY cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StBusy;
                        count_q    <= '0;
                        op_q       <= op;
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= (b == 32'd0);
                        dividend_q <= a;
                        divisor_q  <= b_mag;
                        rem_q      <= '0;
                        prod_q     <= '0;
                        mcand_q    <= {32'd0, a_mag};
                        shreg_q    <= op[2] ? a_mag : b_mag;
                    end
                end
                StBusy: begin
                    if (op_q[2]) begin
                        if (!diff[32]) begin
                            rem_q   <= diff[31:0];
                            shreg_q <= {shreg_q[30:0], 1'b1};
                        end else begin
                            rem_q   <= rem_shift[31:0];
                            shreg_q <= {shreg_q[30:0], 1'b0};
                        end
                    end else begin
                        if (shreg_q[0]) prod_q <= prod_q + mcand_q;
                        mcand_q <= mcand_q << 1;
                        shreg_q <= shreg_q >> 1;
                    end
                    count_q <= count_q + CntW'(1);
                    if (count_q == CntW'(MULDIV_ITERS - 1)) state_q <= StDone;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative mul/div
// and the EX/MEM pipeline register.
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MULDIV_ITERS = 32
) (
    input  logic     clock,
    input  logic     reset_n,
    ex_stage_if.slave bus
);
    logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_b, alu_result, md_result;
    logic [4:0]      shamt;
    logic            md_busy, md_done;

    // Forward from EX/MEM first, then WB, else the ID/EX value; x0 never forwards.
    always_comb begin
        fwd_rs1 = bus.ex_rs1_data;
        if (bus.mem_reg_write && bus.mem_rd == bus.ex_rs1 && bus.ex_rs1 != 5'd0) begin
            fwd_rs1 = bus.mem_alu_result;
        end else if (bus.wb_reg_write && bus.wb_rd == bus.ex_rs1 && bus.ex_rs1 != 5'd0) begin
            fwd_rs1 = bus.wb_data;
        end
        fwd_rs2 = bus.ex_rs2_data;
        if (bus.mem_reg_write && bus.mem_rd == bus.ex_rs2 && bus.ex_rs2 != 5'd0) begin
            fwd_rs2 = bus.mem_alu_result;
        end else if (bus.wb_reg_write && bus.wb_rd == bus.ex_rs2 && bus.ex_rs2 != 5'd0) begin
            fwd_rs2 = bus.wb_data;
        end
    end

    // Single-cycle ALU on the forwarded A and selected B operand.
    always_comb begin
        op_b       = bus.ex_alu_use_rs2 ? fwd_rs2 : bus.ex_immediate;
        shamt      = op_b[4:0];
        alu_result = '0;
        case (bus.ex_alu_op)
            OpAdd:   alu_result = fwd_rs1 + op_b;
            OpSub:   alu_result = fwd_rs1 - op_b;
            OpSll:   alu_result = fwd_rs1 << shamt;
            OpSlt:   alu_result = {{(XLEN-1){1'b0}}, $signed(fwd_rs1) < $signed(op_b)};
            OpSltu:  alu_result = {{(XLEN-1){1'b0}}, fwd_rs1 < op_b};
            OpXor:   alu_result = fwd_rs1 ^ op_b;
            OpSrl:   alu_result = fwd_rs1 >> shamt;
            OpSra:   alu_result = $signed(fwd_rs1) >>> shamt;
            OpOr:    alu_result = fwd_rs1 | op_b;
            OpAnd:   alu_result = fwd_rs1 & op_b;
            OpPassB: alu_result = op_b;
            default: alu_result = '0;
        endcase
    end

    ex_muldiv_unit #(
        .MULDIV_ITERS(MULDIV_ITERS)
    ) u_muldiv (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (is_muldiv(bus.ex_alu_op)),
        .op     (bus.ex_alu_op),
        .a      (fwd_rs1),
        .b      (op_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign bus.ex_stall = md_busy;

    // EX/MEM register; while stalled the slot becomes a bubble and data fields hold.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.mem_alu_result    <= '0;
            bus.mem_rs2_data      <= '0;
            bus.mem_rd            <= '0;
            bus.mem_reg_write     <= 1'b0;
            bus.mem_mem_write     <= 1'b0;
            bus.mem_mem_read      <= 1'b0;
            bus.mem_mem_op_length <= '0;
        end else if (md_busy) begin
            bus.mem_reg_write <= 1'b0;
            bus.mem_mem_write <= 1'b0;
            bus.mem_mem_read  <= 1'b0;
        end else begin
            bus.mem_alu_result    <= md_done ? md_result : alu_result;
            bus.mem_rs2_data      <= fwd_rs2;
            bus.mem_rd            <= bus.ex_rd;
            bus.mem_reg_write     <= bus.ex_reg_write;
            bus.mem_mem_write     <= bus.ex_mem_write;
            bus.mem_mem_read      <= bus.ex_mem_read;
            bus.mem_mem_op_length <= bus.ex_mem_op_length;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage against a behavioural model.
module tb_ex_stage;
    import ex_pkg::*;

    localparam int unsigned Iters = 32;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    ex_stage_if bus ();

    ex_stage #(
        .XLEN        (32),
        .MULDIV_ITERS(Iters)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0]  op, rd, rs1, rs2;
        logic [31:0] d1, d2, imm;
        logic        use_rs2, rw, mw, mr;
        logic [2:0]  len;
        logic [4:0]  wb_rd;
        logic        wb_rw;
        logic [31:0] wb_data;
    } instr_t;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the EX/MEM register contents.
    logic [31:0] exp_res, exp_st;
    logic [4:0]  exp_rd;
    logic        exp_rw, exp_mw, exp_mr;
    logic [2:0]  exp_len;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        check_eq({tag, "_res"}, bus.mem_alu_result, exp_res);
        check_eq({tag, "_st"}, bus.mem_rs2_data, exp_st);
        check_eq({tag, "_ctl"},
                 {bus.mem_rd, bus.mem_reg_write, bus.mem_mem_write, bus.mem_mem_read,
                  bus.mem_mem_op_length},
                 {exp_rd, exp_rw, exp_mw, exp_mr, exp_len});
    endtask

    // RV32IM semantics straight from the ISA rules, using wide arithmetic.
    function automatic logic [31:0] ref_op(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OpAdd:    return a + b;
            OpSub:    return a - b;
            OpSll:    return a << b[4:0];
            OpSlt:    return {31'd0, $signed(a) < $signed(b)};
            OpSltu:   return {31'd0, a < b};
            OpXor:    return a ^ b;
            OpSrl:    return a >> b[4:0];
            OpSra:    return $signed(a) >>> b[4:0];
            OpOr:     return a | b;
            OpAnd:    return a & b;
            OpPassB:  return b;
            OpMul:    begin p = sa * sb; return p[31:0]; end
            OpMulh:   begin p = sa * sb; return p[63:32]; end
            OpMulhsu: begin p = sa * longint'(ub); return p[63:32]; end
            OpMulhu:  begin p = ua * ub; return p[63:32]; end
            OpDiv:    return (b == 0) ? 32'hffff_ffff : 32'(sa / sb);
            OpDivu:   return (b == 0) ? 32'hffff_ffff : a / b;
            OpRem:    return (b == 0) ? a : 32'(sa % sb);
            OpRemu:   return (b == 0) ? a : a % b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] idx, logic [31:0] raw, instr_t t);
        if (idx != 0 && exp_rw && exp_rd == idx) return exp_res;
        if (idx != 0 && t.wb_rw && t.wb_rd == idx) return t.wb_data;
        return raw;
    endfunction

    function automatic instr_t mk(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1,
                                  logic [4:0] rs2, logic [31:0] d1, logic [31:0] d2,
                                  logic [31:0] imm, logic use_rs2);
        instr_t t;
        t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
        t.d1 = d1; t.d2 = d2; t.imm = imm; t.use_rs2 = use_rs2;
        t.rw = 1'b1; t.mw = 1'b0; t.mr = 1'b0; t.len = 3'd0;
        t.wb_rd = 5'd0; t.wb_rw = 1'b0; t.wb_data = 32'd0;
        return t;
    endfunction

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hffff_ffff;
            3:       return 32'h8000_0000;
            4:       return 32'h7fff_ffff;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [4:0] rand_op();
        int unsigned k;
        k = $urandom_range(0, 22);
        if (k <= 10) return 5'(k);
        if (k <= 18) return 5'(k + 5);
        return 5'(k - 8);
    endfunction

    task automatic drive(input instr_t t);
        bus.ex_alu_op        = t.op;
        bus.ex_rd            = t.rd;
        bus.ex_rs1           = t.rs1;
        bus.ex_rs2           = t.rs2;
        bus.ex_rs1_data      = t.d1;
        bus.ex_rs2_data      = t.d2;
        bus.ex_immediate     = t.imm;
        bus.ex_alu_use_rs2   = t.use_rs2;
        bus.ex_reg_write     = t.rw;
        bus.ex_mem_write     = t.mw;
        bus.ex_mem_read      = t.mr;
        bus.ex_mem_op_length = t.len;
        bus.wb_rd            = t.wb_rd;
        bus.wb_reg_write     = t.wb_rw;
        bus.wb_data          = t.wb_data;
    endtask

    // Issue one instruction at a falling edge and follow it until it lands in EX/MEM.
    task automatic run(input string tag, input instr_t t);
        logic [31:0] a, st, opb, r;
        int          stalls;
        drive(t);
        #1;
        a   = fwd(t.rs1, t.d1, t);
        st  = fwd(t.rs2, t.d2, t);
        opb = t.use_rs2 ? st : t.imm;
        r   = ref_op(t.op, a, opb);
        if (t.op[4]) begin
            stalls = 0;
            while (bus.ex_stall === 1'b1 && stalls < 100) begin
                stalls++;
                @(posedge clock);
                @(negedge clock);
                exp_rw = 1'b0;
                exp_mw = 1'b0;
                exp_mr = 1'b0;
                check_mem({tag, "_bubble"});
            end
            check_eq({tag, "_stalls"}, 64'(stalls), 64'(Iters + 1));
            st = fwd(t.rs2, t.d2, t);
        end else begin
            check_eq({tag, "_nostall"}, bus.ex_stall, 0);
        end
        @(posedge clock);
        @(negedge clock);
        exp_res = r;
        exp_st  = st;
        exp_rd  = t.rd;
        exp_rw  = t.rw;
        exp_mw  = t.mw;
        exp_mr  = t.mr;
        exp_len = t.len;
        check_mem(tag);
    endtask

    task automatic apply_reset(input string tag, input int cycles);
        reset_n          = 1'b0;
        bus.ex_alu_op    = OpAdd;
        bus.ex_reg_write = 1'b1;
        repeat (cycles) begin
            @(posedge clock);
            @(negedge clock);
        end
        exp_res = '0; exp_st = '0; exp_rd = '0;
        exp_rw = 1'b0; exp_mw = 1'b0; exp_mr = 1'b0; exp_len = '0;
        check_eq({tag, "_stall"}, bus.ex_stall, 0);
        check_mem(tag);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        instr_t t;
        reset_n = 1'b0;
        drive(mk(OpAdd, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        apply_reset("reset", 2);

        // Forwarding priority: EX/MEM x5=3 beats WB x5=9.
        run("fwd_setup", mk(OpAdd, 5, 0, 0, 0, 0, 3, 0));
        t = mk(OpAdd, 6, 5, 5, 0, 0, 0, 1);
        t.wb_rd = 5; t.wb_rw = 1'b1; t.wb_data = 9;
        run("fwd_add", t);
        check_eq("fwd_pri", bus.mem_alu_result, 6);

        // Same with x0: nothing forwards.
        run("x0_setup", mk(OpAdd, 0, 0, 0, 0, 0, 3, 0));
        t = mk(OpAdd, 6, 0, 0, 0, 0, 0, 1);
        t.wb_rd = 0; t.wb_rw = 1'b1; t.wb_data = 9;
        run("x0_add", t);
        check_eq("fwd_x0", bus.mem_alu_result, 0);

        run("sra", mk(OpSra, 1, 0, 0, 32'h8000_0000, 0, 31, 0));
        check_eq("sra_val", bus.mem_alu_result, 32'hffff_ffff);
        run("slt", mk(OpSlt, 1, 0, 0, 32'hffff_ffff, 1, 0, 1));
        check_eq("slt_val", bus.mem_alu_result, 1);
        run("sltu", mk(OpSltu, 1, 0, 0, 32'hffff_ffff, 1, 0, 1));
        check_eq("sltu_val", bus.mem_alu_result, 0);
        run("addw", mk(OpAdd, 1, 0, 0, 32'hffff_ffff, 0, 1, 0));
        check_eq("addw_val", bus.mem_alu_result, 0);

        run("mul", mk(OpMul, 7, 0, 0, 32'hffff_fffd, 7, 0, 1));
        check_eq("mul_val", bus.mem_alu_result, 32'hffff_ffeb);
        check_eq("mul_rw", bus.mem_reg_write, 1);
        run("mulhu", mk(OpMulhu, 7, 0, 0, 32'hffff_ffff, 32'hffff_ffff, 0, 1));
        check_eq("mulhu_val", bus.mem_alu_result, 32'hffff_fffe);
        run("div0", mk(OpDiv, 7, 0, 0, 10, 0, 0, 1));
        check_eq("div0_val", bus.mem_alu_result, 32'hffff_ffff);
        run("rem0", mk(OpRem, 7, 0, 0, 10, 0, 0, 1));
        check_eq("rem0_val", bus.mem_alu_result, 10);
        run("divov", mk(OpDiv, 7, 0, 0, 32'h8000_0000, 32'hffff_ffff, 0, 1));
        check_eq("divov_val", bus.mem_alu_result, 32'h8000_0000);
        run("remov", mk(OpRem, 7, 0, 0, 32'h8000_0000, 32'hffff_ffff, 0, 1));
        check_eq("remov_val", bus.mem_alu_result, 0);
        run("divu", mk(OpDivu, 7, 0, 0, 100, 7, 0, 1));
        check_eq("divu_val", bus.mem_alu_result, 14);
        run("remu", mk(OpRemu, 7, 0, 0, 100, 7, 0, 1));
        check_eq("remu_val", bus.mem_alu_result, 2);

        apply_reset("midreset", 2);

        // Abort a divide in its tenth BUSY cycle.
        drive(mk(OpDiv, 3, 0, 0, 1000, 3, 0, 1));
        #1;
        check_eq("abort_start", bus.ex_stall, 1);
        repeat (10) @(posedge clock);
        @(negedge clock);
        check_eq("abort_busy", bus.ex_stall, 1);
        check_eq("abort_bubble", bus.mem_reg_write, 0);
        apply_reset("abort", 1);
        run("div_after", mk(OpDiv, 3, 0, 0, 21, 4, 0, 1));
        check_eq("div_after_val", bus.mem_alu_result, 5);

        for (int i = 0; i < 80; i++) begin
            t = mk(rand_op(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), rv(), rv(), rv(), 1'($urandom_range(0, 1)));
            t.rw      = 1'($urandom_range(0, 1));
            t.mw      = 1'($urandom_range(0, 1));
            t.mr      = 1'($urandom_range(0, 1));
            t.len     = 3'($urandom_range(0, 7));
            t.wb_rd   = 5'($urandom_range(0, 7));
            t.wb_rw   = 1'($urandom_range(0, 1));
            t.wb_data = rv();
            run("rand", t);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
